// File: rtl/reg_temp_filter.sv
// reg_temp_filter: temperature sample register with circular history, moving average,
// min/max since clear, fill count and hysteresis over-temperature alarm.
module reg_temp_filter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int HYST  = 2
) (
    input  logic                     Clk_R,
    input  logic                     Enable_R,
    input  logic                     Load_R,
    input  logic                     Clear_R,
    input  logic [WIDTH-1:0]         DecoT,
    input  logic [WIDTH-1:0]         Thr_Hi,
    output logic [WIDTH-1:0]         Reg_Temp,
    output logic [WIDTH-1:0]         Avg_Temp,
    output logic [WIDTH-1:0]         Max_Temp,
    output logic [WIDTH-1:0]         Min_Temp,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Valid,
    output logic                     Alarm
);
    localparam int LG = $clog2(DEPTH);
    localparam int SW = WIDTH + LG;

    logic [WIDTH-1:0] r_hist [DEPTH];
    logic [LG-1:0]    r_wp;
    logic [SW-1:0]    r_sum;
    logic             r_seen;

    // A simultaneous clear makes the sample land on an empty filter, so every base value folds to zero.
    logic [WIDTH-1:0] w_old, w_thr_lo;
    logic [LG-1:0]    w_wp;
    logic [SW-1:0]    w_sum;
    logic [LG:0]      w_cnt;
    logic             w_seen, w_alarm, w_next_alarm;

    assign w_old        = Clear_R ? '0 : r_hist[r_wp];
    assign w_wp         = Clear_R ? '0 : r_wp;
    assign w_sum        = Clear_R ? '0 : r_sum;
    assign w_cnt        = Clear_R ? '0 : Count;
    assign w_seen       = ~Clear_R & r_seen;
    assign w_alarm      = ~Clear_R & Alarm;
    assign w_thr_lo     = (Thr_Hi > WIDTH'(HYST)) ? Thr_Hi - WIDTH'(HYST) : '0;
    assign w_next_alarm = (DecoT >= Thr_Hi) | (w_alarm & ~(DecoT < w_thr_lo));

    assign Avg_Temp = WIDTH'(r_sum >> LG);
    assign Valid    = (Count == (LG+1)'(DEPTH));

    always_ff @(posedge Clk_R or negedge Enable_R) begin
        if (!Enable_R) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_wp     <= '0;
            r_sum    <= '0;
            r_seen   <= 1'b0;
            Count    <= '0;
            Reg_Temp <= '0;
            Max_Temp <= '0;
            Min_Temp <= '0;
            Alarm    <= 1'b0;
        end else begin
            if (Clear_R) begin
                for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
                r_wp     <= '0;
                r_sum    <= '0;
                r_seen   <= 1'b0;
                Count    <= '0;
                Reg_Temp <= '0;
                Max_Temp <= '0;
                Min_Temp <= '0;
                Alarm    <= 1'b0;
            end
            if (Load_R) begin
                r_hist[w_wp] <= DecoT;
                r_wp         <= w_wp + LG'(1);
                r_sum        <= w_sum + SW'(DecoT) - SW'(w_old);
                r_seen       <= 1'b1;
                Count        <= (w_cnt == (LG+1)'(DEPTH)) ? w_cnt : w_cnt + (LG+1)'(1);
                Reg_Temp     <= DecoT;
                Max_Temp     <= (!w_seen || DecoT > Max_Temp) ? DecoT : Max_Temp;
                Min_Temp     <= (!w_seen || DecoT < Min_Temp) ? DecoT : Min_Temp;
                Alarm        <= w_next_alarm;
            end
        end
    end
endmodule
